// File: rtl/byte_serial_dmem.sv
// Data-memory responder: serves RV32I loads/stores one byte per cycle over a
// byte-wide synchronous SRAM, little-endian, stalling the pipeline meanwhile.
module byte_serial_dmem #(
    parameter int SRAM_AW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               req_ready,
    output logic               stall,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic               sram_en,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [7:0]         sram_wdata,
    input  logic [7:0]         sram_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]         state;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [SRAM_AW-1:0] base_q;
    logic [31:0]        wdata_q;
    logic [1:0]         k;
    logic [31:0]        rbuf;

    logic               req_err;
    logic [1:0]         last_k;
    logic [1:0]         k_nxt;
    logic [1:0]         cap_idx;
    logic [31:0]        rbuf_cap;
    logic [31:0]        load_ext;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:SRAM_AW];

    assign req_ready = (state == IDLE);
    assign stall     = req_valid && !resp_valid;

    always_comb begin
        req_err = 1'b0;
        if (req_funct3[1:0] == 2'b11)                            req_err = 1'b1;
        if (!req_we && (req_funct3[2:1] == 2'b11))               req_err = 1'b1;
        if (req_we && req_funct3[2])                             req_err = 1'b1;
        if ((req_funct3[1:0] == 2'b01) && req_addr[0])           req_err = 1'b1;
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != '0)) req_err = 1'b1;
    end

    assign last_k = f3_q[1] ? 2'd3 : {1'b0, f3_q[0]};
    assign k_nxt  = k + 2'd1;

    // SRAM read data lags the issued address by one cycle, so ISSUE stores the
    // previous byte and CAPTURE stores the final one (still indexed by k).
    assign cap_idx = (state == CAPTURE) ? k : k - 2'd1;

    always_comb begin
        rbuf_cap = rbuf;
        rbuf_cap[{cap_idx, 3'b000} +: 8] = sram_rdata;
    end

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{24{rbuf_cap[7]}}, rbuf_cap[7:0]};
            3'b001:  load_ext = {{16{rbuf_cap[15]}}, rbuf_cap[15:0]};
            3'b100:  load_ext = {24'h0, rbuf_cap[7:0]};
            3'b101:  load_ext = {16'h0, rbuf_cap[15:0]};
            default: load_ext = rbuf_cap;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            k          <= '0;
            rbuf       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        base_q  <= req_addr[SRAM_AW-1:0];
                        wdata_q <= req_wdata;
                        k       <= '0;
                        rbuf    <= '0;
                        if (req_err) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state      <= ISSUE;
                            sram_en    <= 1'b1;
                            sram_we    <= req_we;
                            sram_addr  <= req_addr[SRAM_AW-1:0];
                            sram_wdata <= req_wdata[7:0];
                        end
                    end
                end
                ISSUE: begin
                    if (!we_q && (k != '0)) begin
                        rbuf <= rbuf_cap;
                    end
                    if (k == last_k) begin
                        sram_en <= 1'b0;
                        sram_we <= 1'b0;
                        if (we_q) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end else begin
                            state <= CAPTURE;
                        end
                    end else begin
                        k          <= k_nxt;
                        sram_addr  <= base_q + SRAM_AW'(k_nxt);
                        sram_wdata <= wdata_q[{k_nxt, 3'b000} +: 8];
                    end
                end
                CAPTURE: begin
                    rbuf       <= rbuf_cap;
                    state      <= DONE;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_ext;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_dmem.sv
// Bench for byte_serial_dmem: directed vector table, async-reset abort sequence,
// and random requests checked against an array-based memory/ISA model.
module tb_byte_serial_dmem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, stall, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        sram_en, sram_we;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata = '0;

    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];

    int errors = 0;
    int checks = 0;

    byte_serial_dmem #(.SRAM_AW(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous byte SRAM plus a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic int width_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // ISA-level reference: decides error/latency/result and updates ref_mem.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err,
                                  output int lat);
        int n;
        longint v;
        n   = width_of(f3);
        err = (n == 0);
        if (!we && f3 >= 3'd6) err = 1'b1;
        if (we && f3[2])       err = 1'b1;
        if (n != 0 && (addr % n) != 0) err = 1'b1;
        rd = '0;
        if (err) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < n; i++)
                ref_mem[(addr + i) & 32'hFFFF] = 8'((wd >> (8 * i)) & 32'hFF);
            lat = n + 1;
        end else begin
            v = 0;
            for (int i = 0; i < n; i++)
                v += longint'(ref_mem[(addr + i) & 32'hFFFF]) << (8 * i);
            if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v -= (longint'(1) << (8 * n));
            rd  = v[31:0];
            lat = n + 2;
        end
    endfunction

    // Issues one request (entered at posedge+1) and checks timing, SRAM traffic and response.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input int exp_lat, input string nm);
        int          lat = -1;
        int          nbytes = 0;
        int          exp_n;
        logic        seq_bad = 1'b0;
        logic        stall_bad = 1'b0;
        logic        ready0 = 1'b0;
        logic [31:0] got_rd = '0;
        logic        got_err = 1'b0;
        exp_n      = exp_err ? 0 : width_of(f3);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 0) ready0 = req_ready;
            if (stall !== (c != exp_lat)) stall_bad = 1'b1;
            if (sram_en === 1'b1) begin
                if (nbytes >= exp_n || sram_addr !== 16'(addr + nbytes) || sram_we !== we ||
                    (we && sram_wdata !== wd[8 * nbytes +: 8]))
                    seq_bad = 1'b1;
                nbytes++;
            end
            if (resp_valid === 1'b1) begin
                lat     = c;
                got_rd  = resp_rdata;
                got_err = resp_err;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (nbytes != exp_n) seq_bad = 1'b1;
        chk({nm, "_ready"}, 32'(ready0), 32'd1);
        chk({nm, "_lat"},   32'(lat), 32'(exp_lat));
        chk({nm, "_rdata"}, got_rd, exp_rd);
        chk({nm, "_err"},   32'(got_err), 32'(exp_err));
        chk({nm, "_sram_seq_bad"}, 32'(seq_bad), 32'd0);
        chk({nm, "_stall_bad"},    32'(stall_bad), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] v);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = v;
        ref_mem[a] = v;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] erd;
        logic        eerr;
        int          elat;
        int          bad;
        logic [31:0] r;
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  low;
        logic [31:0] wd;

        tbl[0]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 6};
        tbl[1]  = '{1'b1, 3'b000, 32'h0000_0021, 32'hAABB_CCDD, 32'h0,         1'b0, 2};
        tbl[2]  = '{1'b0, 3'b001, 32'h0000_0030, 32'h0,         32'hFFFF_FF80, 1'b0, 4};
        tbl[3]  = '{1'b0, 3'b101, 32'h0000_0030, 32'h0,         32'h0000_FF80, 1'b0, 4};
        tbl[4]  = '{1'b0, 3'b000, 32'h0000_0030, 32'h0,         32'hFFFF_FF80, 1'b0, 3};
        tbl[5]  = '{1'b0, 3'b100, 32'h0000_0030, 32'h0,         32'h0000_0080, 1'b0, 3};
        tbl[6]  = '{1'b0, 3'b010, 32'h0000_0002, 32'h0,         32'h0,         1'b1, 1};
        tbl[7]  = '{1'b1, 3'b001, 32'h0000_0005, 32'h1234_5678, 32'h0,         1'b1, 1};
        tbl[8]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 1};
        tbl[9]  = '{1'b1, 3'b010, 32'hABCD_FFFC, 32'hCAFE_BABE, 32'h0,         1'b0, 5};
        tbl[10] = '{1'b0, 3'b110, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 1};
        tbl[11] = '{1'b1, 3'b100, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 1};

        for (int a = 0; a < 256; a++) preload(16'(a), 8'(a) ^ 8'h5A);
        for (int a = 16'hFFF0; a <= 16'hFFFF; a++) preload(16'(a), 8'(a) ^ 8'h5A);
        preload(16'h0010, 8'h78);
        preload(16'h0011, 8'h56);
        preload(16'h0012, 8'h34);
        preload(16'h0013, 8'h12);
        preload(16'h0030, 8'h80);
        preload(16'h0031, 8'hFF);

        idle(1);
        rst = 1'b0;
        idle(1);
        @(negedge clk);
        chk("reset_state", {req_ready, resp_valid, resp_err, sram_en, sram_we, stall},
            32'b100000);
        chk("reset_rdata", resp_rdata, 32'h0);
        chk("reset_sram_addr", {sram_wdata, sram_addr}, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, erd, eerr, elat);
            run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                    tbl[i].rd, tbl[i].err, tbl[i].lat, $sformatf("vec%0d", i));
        end

        chk("sb_written",  32'(mem[16'h0021]), 32'hDD);
        chk("sb_below",    32'(mem[16'h0020]), 32'(8'h20 ^ 8'h5A));
        chk("sb_above",    32'(mem[16'h0022]), 32'(8'h22 ^ 8'h5A));
        chk("sw_top_word", {mem[16'hFFFF], mem[16'hFFFE], mem[16'hFFFD], mem[16'hFFFC]},
            32'hCAFE_BABE);

        // Abort a store with async reset while its second byte is on the bus.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0040;
        req_wdata  = 32'h1122_3344;
        idle(2);
        @(negedge clk);
        chk("abort_pre", {15'h0, sram_en, sram_addr}, {15'h0, 1'b1, 16'h0041});
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("abort_async", {req_ready, resp_valid, sram_en, sram_we}, 32'b1000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_mem[16'h0040] = 8'h44;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || sram_en !== 1'b0) bad++;
        end
        chk("abort_quiet", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        model(1'b0, 3'b010, 32'h40, 32'h0, erd, eerr, elat);
        run_req(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h1918_1B44, 1'b0, 6, "after_abort");

        for (int t = 0; t < 40; t++) begin
            r  = $urandom;
            we = r[0];
            case ($urandom_range(0, 9))
                0, 5:    f3 = 3'b000;
                1, 6:    f3 = 3'b001;
                2, 7:    f3 = 3'b010;
                3:       f3 = 3'b100;
                4:       f3 = 3'b101;
                8:       f3 = 3'b011;
                default: f3 = 3'b111;
            endcase
            low = 8'($urandom_range(0, 16'hF8));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) low[0]   = 1'b0;
                if (f3[1:0] == 2'b10) low[1:0] = 2'b00;
            end
            wd = $urandom;
            model(we, f3, {r[31:16], 8'h00, low}, wd, erd, eerr, elat);
            run_req(we, f3, {r[31:16], 8'h00, low}, wd, erd, eerr, elat,
                    $sformatf("rnd%0d", t));
            idle($urandom_range(0, 2));
        end

        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
        for (int a = 16'hFFF0; a <= 16'hFFFF; a++) if (mem[a] !== ref_mem[a]) bad++;
        chk("final_mem_mismatches", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
